// File: rtl/vram_bus_responder.sv
// Splits each 32-bit bus read into two halfword VRAM reads.
// The assembled word is returned with a one-cycle ack.
module vram_bus_responder #(
  parameter int READ_LATENCY = 1,
  parameter int VRAM_BYTES   = 131072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] bus_addr,
  input  logic        bus_strobe,
  output logic [31:0] bus_data,
  output logic        bus_ack,
  output logic [16:0] mem_addr,
  output logic        mem_rden,
  input  logic [15:0] mem_rddata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WAIT,
    ACK
  } state_t;

  localparam logic [2:0]  LAT_M1   = 3'(READ_LATENCY - 1);
  localparam logic [18:0] LIMIT    = 19'(VRAM_BYTES);
  localparam bit          LO_IN_HI = (READ_LATENCY == 1);

  state_t      state;
  logic [15:0] a_q;
  logic [15:0] lo_q;
  logic [2:0]  cnt;
  logic [1:0]  pre;
  logic        oor;
  logic        in_range;

  assign in_range = {1'b0, bus_addr} < LIMIT;

  // pre pads out-of-range requests by the two read-issue cycles
  // they skip, so their ack lands on the same edge as a real read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      lo_q     <= '0;
      cnt      <= '0;
      pre      <= '0;
      oor      <= 1'b0;
      bus_data <= '0;
      bus_ack  <= 1'b0;
      mem_addr <= '0;
      mem_rden <= 1'b0;
    end else begin
      bus_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus_strobe) begin
            a_q <= bus_addr[17:2];
            cnt <= LAT_M1;
            if (in_range) begin
              mem_addr <= {bus_addr[17:2], 1'b0};
              mem_rden <= 1'b1;
              oor      <= 1'b0;
              pre      <= 2'd0;
              state    <= RD_LO;
            end else begin
              oor   <= 1'b1;
              pre   <= 2'd2;
              state <= WAIT;
            end
          end
        end
        RD_LO: begin
          mem_addr <= {a_q, 1'b1};
          state    <= RD_HI;
        end
        RD_HI: begin
          mem_rden <= 1'b0;
          if (LO_IN_HI) lo_q <= mem_rddata;
          state <= WAIT;
        end
        WAIT: begin
          if (pre != 2'd0) begin
            pre <= pre - 2'd1;
          end else if (cnt == 3'd0) begin
            bus_data <= oor ? 32'h0
                            : {mem_rddata, lo_q};
            bus_ack  <= 1'b1;
            state    <= ACK;
          end else begin
            if (!LO_IN_HI && cnt == 3'd1)
              lo_q <= mem_rddata;
            cnt <= cnt - 3'd1;
          end
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
